hazard_pause_ctrl: RTL and testbench
====================================

// Module: hazard_pause_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage vector pipeline (IF/ID/EX/MEM/WB).
//  - Detects RAW hazards between ID read addresses and pending writes in EX/MEM/WB.
//    The pipeline has no forwarding, so the controller stalls IF/ID and injects bubbles into EX.
//  - Applies control-flow flushes.
//  - Runs a host pause handshake that drains the pipe before acknowledging.
//  - Keeps a hazard-stall performance counter.
//  Drives the stall/flush enables of segment_if_id and segment_id_ex.
// PARAMETERS
//  AW         4   register-address width (16 vector registers)
//  CW         16  stall-counter width
//  WB_BYPASS  0   1 = regfile write-through, so a WB-stage match is not a hazard
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  RA1D         in   AW  ID source address 1 (InstrD[20:17])
//  RA2D         in   AW  ID source address 2 (RA2 mux output)
//  UsesRA1D     in   1   ID instruction reads RA1D
//  UsesRA2D     in   1   ID instruction reads RA2D
//  RegWriteE/M/W in  1   stage writes regfile
//  WA3E/M/W     in   AW  stage destination address
//  BranchE      in   1   control-type instruction in EX redirects PC
//  pause_req    in   1   host pause request, level
//  stat_clr     in   1   synchronous clear of stall_count
//  StallF       out  1   hold PC
//  StallD       out  1   hold IF/ID register
//  FlushD       out  1   clear IF/ID register
//  FlushE       out  1   clear ID/EX register (bubble)
//  paused       out  1   pipe empty and frozen
//  stall_count  out  CW  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN; validD/E/M/W=0; stall_count=0.
//    All outputs are 0 while in reset and in the first cycle after release.
//  Occupancy (registered, every cycle):
//    validD <= FlushD ? 0 : StallD ? validD : 1
//    validE <= FlushE ? 0 : validD
//    validM <= validE;  validW <= validM
//  Hazard (combinational):
//    hazard = validD & (src1 | src2)
//    srcN = UsesRAN & ((validE&RegWriteE&WA3E==RAN) | (validM&RegWriteM&WA3M==RAN)
//           | (!WB_BYPASS & validW&RegWriteW&WA3W==RAN))
//  Outputs are combinational from state and inputs. Priority:
//    1) BranchE (any state except PAUSED): FlushD=1, FlushE=1, StallF=0, StallD=0.
//    2) state DRAIN or PAUSED: StallF=1, StallD=1, FlushE=1.
//    3) hazard: StallF=1, StallD=1, FlushE=1.
//    4) else all 0.
//  FSM:
//    RUN    -> DRAIN  when pause_req=1.
//    DRAIN  -> PAUSED when validE|validM|validW == 0 and BranchE=0 (evaluated on the clock edge).
//    PAUSED -> RUN    when pause_req=0; outputs release in the first RUN cycle.
//    DRAIN  -> RUN    if pause_req drops before empty.
//  paused = (state==PAUSED), registered.
//  The held ID instruction survives pause and re-issues after resume, with hazards re-evaluated.
//  stall_count: increments only when rule 3 is the active rule. Saturates at 2^CW-1.
//    stat_clr wins over a same-cycle increment.
//  Reset asserted mid-stall or mid-drain returns to RUN with no residual stall.
// TESTING
//  T1 Assert reset mid-hazard -> all outputs 0 same cycle; stall_count=0; after release, RUN.
//  T2 EX writes r7, ID reads r7 (RA1D=7) -> StallF/StallD/FlushE=1 for 3 cycles, 0 on 4th;
//     stall_count=3. With WB_BYPASS=1: 2 cycles, stall_count=2.
//  T3 BranchE=1 while ID has a RAW hazard -> FlushD=FlushE=1, StallF=StallD=0;
//     stall_count unchanged.
//  T4 Three writes in flight, pause_req=1 -> DRAIN 3 cycles, paused=1 on 4th edge;
//     pause_req=0 -> paused=0 and StallF=0 next cycle.
//  T5 CW=4, hazard held 20 cycles -> stall_count saturates at 15.
//     stat_clr coincident with an increment -> stall_count=0.
//  T6 UsesRA2D=0, RA2D matches WA3E -> no stall. RA1D and RA2D both hazard -> single stall sequence.

Source files
------------

// File: rtl/hazard_pause_if.sv
// Control bundle between the pipeline sequencing controller and the pipeline/host side.
// The master drives the hazard/pause inputs; the slave (controller) drives the stall/flush enables.
interface hazard_pause_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned CW = 16
);
    logic [AW-1:0] RA1D;
    logic [AW-1:0] RA2D;
    logic          UsesRA1D;
    logic          UsesRA2D;
    logic          RegWriteE;
    logic          RegWriteM;
    logic          RegWriteW;
    logic [AW-1:0] WA3E;
    logic [AW-1:0] WA3M;
    logic [AW-1:0] WA3W;
    logic          BranchE;
    logic          pause_req;
    logic          stat_clr;
    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic          paused;
    logic [CW-1:0] stall_count;

    modport master (
        output RA1D, RA2D, UsesRA1D, UsesRA2D,
        output RegWriteE, RegWriteM, RegWriteW, WA3E, WA3M, WA3W,
        output BranchE, pause_req, stat_clr,
        input  StallF, StallD, FlushD, FlushE, paused, stall_count
    );

    modport slave (
        input  RA1D, RA2D, UsesRA1D, UsesRA2D,
        input  RegWriteE, RegWriteM, RegWriteW, WA3E, WA3M, WA3W,
        input  BranchE, pause_req, stat_clr,
        output StallF, StallD, FlushD, FlushE, paused, stall_count
    );
endinterface

// File: rtl/hazard_pause_ctrl.sv
// Sequencing controller for the 5-stage vector pipeline: RAW-hazard stalls, branch flushes,
// host pause with pipe drain, and a saturating hazard-stall counter.
module hazard_pause_ctrl #(
    parameter int unsigned AW        = 4,
    parameter int unsigned CW        = 16,
    parameter int unsigned WB_BYPASS = 0
) (
    input  logic          clk,
    input  logic          reset,
    hazard_pause_if.slave bus
);

    localparam logic [CW-1:0] LP_CNT_MAX  = {CW{1'b1}};
    localparam logic          LP_CHECK_WB = (WB_BYPASS == 0);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PAUSED
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_armed;
    logic          r_vd;
    logic          r_ve;
    logic          r_vm;
    logic          r_vw;
    logic [CW-1:0] r_stall_cnt;

    logic [AW-1:0] w_ra1;
    logic [AW-1:0] w_ra2;
    logic          w_hit1;
    logic          w_hit2;
    logic          w_hazard;
    logic          w_empty;
    logic          w_stall_f;
    logic          w_stall_d;
    logic          w_flush_d;
    logic          w_flush_e;
    logic          w_count_en;

    assign w_ra1 = bus.RA1D;
    assign w_ra2 = bus.RA2D;

    // No forwarding: any valid in-flight write to a source register is a hazard.
    assign w_hit1 = (r_ve & bus.RegWriteE & (bus.WA3E == w_ra1))
                  | (r_vm & bus.RegWriteM & (bus.WA3M == w_ra1))
                  | (LP_CHECK_WB & r_vw & bus.RegWriteW & (bus.WA3W == w_ra1));
    assign w_hit2 = (r_ve & bus.RegWriteE & (bus.WA3E == w_ra2))
                  | (r_vm & bus.RegWriteM & (bus.WA3M == w_ra2))
                  | (LP_CHECK_WB & r_vw & bus.RegWriteW & (bus.WA3W == w_ra2));

    assign w_hazard = r_vd & ((bus.UsesRA1D & w_hit1) | (bus.UsesRA2D & w_hit2));
    assign w_empty  = ~(r_ve | r_vm | r_vw);

    // Next state and prioritised stall/flush enables; r_armed keeps everything quiet
    // during the first cycle after reset release.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_count_en  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.pause_req) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.pause_req)                w_state_nxt = ST_RUN;
                else if (w_empty && !bus.BranchE)  w_state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!bus.pause_req) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (r_armed) begin
            if (bus.BranchE && (r_state != ST_PAUSED)) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (r_state != ST_RUN) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_hazard) begin
                w_stall_f  = 1'b1;
                w_stall_d  = 1'b1;
                w_flush_e  = 1'b1;
                w_count_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Stage occupancy tracking and the stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed     <= 1'b0;
            r_vd        <= 1'b0;
            r_ve        <= 1'b0;
            r_vm        <= 1'b0;
            r_vw        <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_armed <= 1'b1;
            r_vd    <= w_flush_d ? 1'b0 : (w_stall_d ? r_vd : 1'b1);
            r_ve    <= ~w_flush_e & r_vd;
            r_vm    <= r_ve;
            r_vw    <= r_vm;
            if (bus.stat_clr)
                r_stall_cnt <= '0;
            else if (w_count_en && (r_stall_cnt != LP_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign bus.StallF      = w_stall_f;
    assign bus.StallD      = w_stall_d;
    assign bus.FlushD      = w_flush_d;
    assign bus.FlushE      = w_flush_e;
    assign bus.paused      = (r_state == ST_PAUSED);
    assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_pause_ctrl.sv
// Scoreboard bench for hazard_pause_ctrl: a driver pushes expected responses from a
// behavioural model, a monitor pops and compares them every cycle.
module tb_hazard_pause_ctrl;

    localparam int unsigned AW  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned WBB = 0;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit          rst_n;
        bit [AW-1:0] ra1, ra2;
        bit          u1, u2, rwe, rwm, rww;
        bit [AW-1:0] wae, wam, waw;
        bit          br, pr, clr;
    } stim_t;

    typedef struct {
        bit sf, sd, fd, fe, pz;
        int cnt;
    } exp_t;

    typedef enum {RUNNING, DRAINING, FROZEN} mmode_e;

    logic clk;
    logic reset;
    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: which stages hold a real instruction, host mode, counter.
    bit     m_vd, m_ve, m_vm, m_vw, m_live;
    mmode_e m_mode;
    int     m_cnt;
    bit     pr_lvl;

    hazard_pause_if #(.AW(AW), .CW(CW)) bus ();

    hazard_pause_ctrl #(.AW(AW), .CW(CW), .WB_BYPASS(WBB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_vd = 0; m_ve = 0; m_vm = 0; m_vw = 0;
        m_live = 0; m_mode = RUNNING; m_cnt = 0;
    endtask

    // Drive one cycle of stimulus, predict the response, then advance the model by one edge.
    task automatic apply(input stim_t s);
        exp_t e;
        int   pend[$];
        bit   hz;
        bit   empty;
        @(negedge clk);
        reset         = s.rst_n;
        bus.RA1D      = s.ra1;   bus.RA2D      = s.ra2;
        bus.UsesRA1D  = s.u1;    bus.UsesRA2D  = s.u2;
        bus.RegWriteE = s.rwe;   bus.RegWriteM = s.rwm;  bus.RegWriteW = s.rww;
        bus.WA3E      = s.wae;   bus.WA3M      = s.wam;  bus.WA3W      = s.waw;
        bus.BranchE   = s.br;    bus.pause_req = s.pr;   bus.stat_clr  = s.clr;

        e = '{default: 0};
        hz = 0;
        if (m_ve && s.rwe) pend.push_back(int'(s.wae));
        if (m_vm && s.rwm) pend.push_back(int'(s.wam));
        if (WBB == 0 && m_vw && s.rww) pend.push_back(int'(s.waw));
        foreach (pend[i])
            if ((s.u1 && pend[i] == int'(s.ra1)) || (s.u2 && pend[i] == int'(s.ra2))) hz = 1;
        hz = hz && m_vd;

        if (s.rst_n && m_live) begin
            if (s.br && m_mode != FROZEN) begin
                e.fd = 1; e.fe = 1;
            end else if (m_mode != RUNNING || hz) begin
                e.sf = 1; e.sd = 1; e.fe = 1;
            end
        end
        e.pz  = s.rst_n && (m_mode == FROZEN);
        e.cnt = s.rst_n ? m_cnt : 0;
        q.push_back(e);

        if (!s.rst_n) begin
            model_reset();
        end else begin
            if (s.clr) m_cnt = 0;
            else if (m_live && hz && !s.br && m_mode == RUNNING && m_cnt < CNT_MAX) m_cnt++;
            empty = !(m_ve || m_vm || m_vw);
            m_vw = m_vm;
            m_vm = m_ve;
            m_ve = e.fe ? 0 : m_vd;
            m_vd = e.fd ? 0 : (e.sd ? m_vd : 1);
            case (m_mode)
                RUNNING:  if (s.pr) m_mode = DRAINING;
                DRAINING: if (!s.pr) m_mode = RUNNING;
                          else if (empty && !s.br) m_mode = FROZEN;
                FROZEN:   if (!s.pr) m_mode = RUNNING;
                default:  m_mode = RUNNING;
            endcase
            m_live = 1;
        end
    endtask

    // Directed helper: all three stages write `wa` when rw=1.
    task automatic dir(input int n, input int ra1, input int ra2, input bit u1, input bit u2,
                       input bit rw, input int wa, input bit br, input bit pr, input bit clr,
                       input bit rst_n);
        stim_t s;
        s.rst_n = rst_n;
        s.ra1 = AW'(ra1); s.ra2 = AW'(ra2); s.u1 = u1; s.u2 = u2;
        s.rwe = rw; s.rwm = rw; s.rww = rw;
        s.wae = AW'(wa); s.wam = AW'(wa); s.waw = AW'(wa);
        s.br = br; s.pr = pr; s.clr = clr;
        repeat (n) apply(s);
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("StallF",      int'(bus.StallF),      int'(e.sf));
            chk("StallD",      int'(bus.StallD),      int'(e.sd));
            chk("FlushD",      int'(bus.FlushD),      int'(e.fd));
            chk("FlushE",      int'(bus.FlushE),      int'(e.fe));
            chk("paused",      int'(bus.paused),      int'(e.pz));
            chk("stall_count", int'(bus.stall_count), e.cnt);
        end
    end

    initial begin
        stim_t s;
        reset = 1'b0;
        bus.RA1D = '0; bus.RA2D = '0; bus.UsesRA1D = 0; bus.UsesRA2D = 0;
        bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.WA3E = '0; bus.WA3M = '0; bus.WA3W = '0;
        bus.BranchE = 0; bus.pause_req = 0; bus.stat_clr = 0;
        model_reset();
        pr_lvl = 0;

        //                n ra1 ra2 u1 u2 rw wa br pr clr rst
        dir(2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset
        dir(3,  0, 0, 1, 0, 1, 7, 0, 0, 0, 1);   // fill pipe with writes to r7
        dir(6,  7, 0, 1, 0, 1, 7, 0, 0, 0, 1);   // RAW on r7
        dir(20, 7, 0, 1, 0, 1, 7, 0, 0, 0, 1);   // repeated stalls -> saturation
        dir(2,  7, 0, 1, 0, 1, 7, 0, 0, 1, 1);   // clear vs increment
        dir(2,  7, 0, 1, 0, 1, 7, 1, 0, 0, 1);   // branch over a hazard
        dir(4,  2, 7, 1, 0, 1, 7, 0, 0, 0, 1);   // unused RA2D match
        dir(6,  7, 7, 1, 1, 1, 7, 0, 0, 0, 1);   // both sources hazard
        dir(3,  0, 0, 0, 0, 1, 5, 0, 0, 0, 1);   // writes in flight
        dir(7,  0, 0, 0, 0, 1, 5, 0, 1, 0, 1);   // pause, drain, paused
        dir(3,  0, 0, 0, 0, 1, 5, 0, 0, 0, 1);   // resume
        dir(2,  3, 0, 1, 0, 1, 3, 0, 1, 0, 1);   // pause over held hazard
        dir(2,  3, 0, 1, 0, 1, 3, 1, 1, 0, 1);   // branch during drain
        dir(4,  3, 0, 1, 0, 1, 3, 0, 1, 0, 1);
        dir(1,  3, 0, 1, 0, 1, 3, 1, 1, 0, 1);   // branch ignored while paused
        dir(4,  3, 0, 1, 0, 1, 3, 0, 0, 0, 1);   // held instruction re-issues
        dir(2,  7, 0, 1, 0, 1, 7, 0, 0, 0, 1);
        dir(1,  7, 0, 1, 0, 1, 7, 0, 0, 0, 0);   // reset mid-hazard
        dir(3,  7, 0, 1, 0, 1, 7, 0, 0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) pr_lvl = !pr_lvl;
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.ra1 = AW'($urandom_range(0, 3));
            s.ra2 = AW'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.rwe = 1'($urandom_range(0, 1));
            s.rwm = 1'($urandom_range(0, 1));
            s.rww = 1'($urandom_range(0, 1));
            s.wae = AW'($urandom_range(0, 3));
            s.wam = AW'($urandom_range(0, 3));
            s.waw = AW'($urandom_range(0, 3));
            s.br  = ($urandom_range(0, 9) == 0);
            s.pr  = pr_lvl;
            s.clr = ($urandom_range(0, 39) == 0);
            apply(s);
        end

        @(negedge clk);
        #6;
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
